serial_shift_unit: RTL and testbench

Multi-cycle shift/rotate unit for the multicycle datapath. It consumes the 5-bit shift amount produced by the shift-amount selector (Shamt, MDR or B) and applies the requested shift or rotate to a 32-bit operand, one bit position per clock cycle. The control unit starts an operation with a `start` pulse and waits for `done` before writing `Data_Out` back to the register file.

---
 rtl/serial_shift_unit_if.sv | 31 +++
 rtl/serial_shift_unit.sv | 97 +++++++++
 tb/tb_serial_shift_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_shift_unit_if.sv
// serial_shift_unit_if: request/result bundle between the control unit and the shift unit.
// Ports carried:
//   start       - one-cycle request, sampled only while the unit is idle
//   ShiftOp     - 3-bit operation select (pass/SLL/SRL/SRA/ROL/ROR, 110/111 pass)
//   ShiftAmt_In - unsigned shift amount N
//   Data_In     - operand
//   Data_Out    - working/result register
//   busy        - high while an operation is in flight (SHIFT and DONE)
//   done        - one-cycle completion pulse
interface serial_shift_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 5
);
    logic                  start;
    logic [2:0]            ShiftOp;
    logic [AMT_WIDTH-1:0]  ShiftAmt_In;
    logic [DATA_WIDTH-1:0] Data_In;
    logic [DATA_WIDTH-1:0] Data_Out;
    logic                  busy;
    logic                  done;

    modport master (
        output start, ShiftOp, ShiftAmt_In, Data_In,
        input  Data_Out, busy, done
    );

    modport slave (
        input  start, ShiftOp, ShiftAmt_In, Data_In,
        output Data_Out, busy, done
    );
endinterface

// File: rtl/serial_shift_unit.sv
// serial_shift_unit: multi-cycle shift/rotate unit, one bit position per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset to IDLE with all registers cleared
//   bus   - serial_shift_unit_if slave (start/ShiftOp/ShiftAmt_In/Data_In in,
//           Data_Out/busy/done out, all outputs registered)
// DATA_WIDTH must equal 2**AMT_WIDTH.
module serial_shift_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_shift_unit_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;
    localparam logic [2:0] OP_ROR = 3'b101;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [AMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] step;
    logic                  real_op;

    // Only SLL..ROR with a non-zero amount needs the SHIFT state; pass,
    // reserved ops and N = 0 go straight to DONE with the operand unchanged.
    assign real_op = (bus.ShiftOp >= OP_SLL) && (bus.ShiftOp <= OP_ROR) &&
                     (bus.ShiftAmt_In != '0);

    always_comb begin
        step = data_q;
        case (op_q)
            OP_SLL:  step = {data_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  step = {1'b0, data_q[DATA_WIDTH-1:1]};
            OP_SRA:  step = {data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]};
            OP_ROL:  step = {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]};
            OP_ROR:  step = {data_q[0], data_q[DATA_WIDTH-1:1]};
            default: step = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (bus.start) begin
                data_d  = bus.Data_In;
                cnt_d   = bus.ShiftAmt_In;
                op_d    = bus.ShiftOp;
                state_d = real_op ? SHIFT : DONE;
            end
            SHIFT: begin
                data_d  = step;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == 1) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
        // Flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Data_Out = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: randomized and directed checks of serial_shift_unit
// against an arithmetic reference model.
module tb_serial_shift_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_shift_unit_if #(.DATA_WIDTH(32), .AMT_WIDTH(5)) bus ();

    serial_shift_unit #(.DATA_WIDTH(32), .AMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [2:0] op, input int n, input logic [31:0] d);
        case (op)
            3'b001:  return d << n;
            3'b010:  return d >> n;
            3'b011:  return 32'($signed(d) >>> n);
            3'b100:  return (n == 0) ? d : ((d << n) | (d >> (32 - n)));
            3'b101:  return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
            default: return d;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input int n);
        return (op >= 3'b001 && op <= 3'b101 && n != 0) ? n : 0;
    endfunction

    // Runs one operation; lat counts edges after E0 until done is seen.
    // When poke is set, a second start with fresh inputs is pulsed mid-SHIFT.
    task automatic do_op(input logic [2:0] op, input logic [4:0] n, input logic [31:0] d,
                         input logic [31:0] exp, input bit poke);
        int lat;
        int exp_lat;
        int dones;
        exp_lat = ref_lat(op, int'(n));
        @(negedge clk);
        bus.start = 1'b1;
        bus.ShiftOp = op;
        bus.ShiftAmt_In = n;
        bus.Data_In = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            check("busy_run", 32'(bus.busy), 32'd1);
            bus.start = poke && (lat == 2);
            bus.ShiftOp = 3'($urandom);
            bus.ShiftAmt_In = 5'($urandom);
            bus.Data_In = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", bus.Data_Out, exp);
        check("busy_done", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(bus.done), 32'd0);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("hold", bus.Data_Out, exp);
        if (poke) begin
            dones = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                dones += int'(bus.done);
            end
            check("no_queue", 32'(dones), 32'd0);
            check("hold_long", bus.Data_Out, exp);
        end
    endtask

    initial begin
        int dones;
        logic [2:0]  op;
        logic [4:0]  n;
        logic [31:0] d;
        bus.start = 1'b0;
        bus.ShiftOp = '0;
        bus.ShiftAmt_In = '0;
        bus.Data_In = '0;
        #1;
        check("rst_data", bus.Data_Out, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(3'b001, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0);
        do_op(3'b011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'b010, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0);
        do_op(3'b101, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b0);
        do_op(3'b100, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0);
        do_op(3'b001, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        do_op(3'b111, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        do_op(3'b100, 5'd9,  32'h1234_5678, ref_shift(3'b100, 9, 32'h1234_5678), 1'b1);

        // Abort a 10-step shift after its third step.
        @(negedge clk);
        bus.start = 1'b1;
        bus.ShiftOp = 3'b001;
        bus.ShiftAmt_In = 5'd10;
        bus.Data_In = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_data", bus.Data_Out, 32'h0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            dones += int'(bus.done);
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_op(3'b011, 5'd5, 32'h8000_00F0, 32'hFC00_0007, 1'b0);

        repeat (40) begin
            op = 3'($urandom);
            n = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d = $urandom;
            do_op(op, n, d, ref_shift(op, int'(n), d), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
